// File: rtl/mc_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_seq
// Description : Multi-cycle control sequencer. Walks each instruction through
//               FETCH/DECODE/EXEC/MEM/WB, drives per-cycle datapath strobes
//               from the decoder control word latched in DECODE, and counts
//               retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_seq #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [13:0]      ctrl_word,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             pc_src,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             mem_byte,
  output logic             alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       reg_dst,
  output logic             mem2reg,
  output logic             reg_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Control word field positions
  localparam int c_MEMBYTE = 13;
  localparam int c_ALUOP   = 12;
  localparam int c_SA      = 11;
  localparam int c_SB_HI   = 10;
  localparam int c_SB_LO   = 9;
  localparam int c_RD_HI   = 8;
  localparam int c_RD_LO   = 7;
  localparam int c_MEM2REG = 6;
  localparam int c_REGW    = 5;
  localparam int c_MEMR    = 4;
  localparam int c_MEMW    = 3;
  localparam int c_PCS     = 2;
  localparam int c_PCWC    = 1;
  localparam int c_PCW     = 0;

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [13:0]       r_ctrl;
  logic              r_bne;
  logic [CNT_W-1:0]  r_retired;

  state_t            w_next;
  logic              w_retire;
  logic              w_unused;

  // Only the low opcode bit matters here (beq vs bne)
  assign w_unused = ^opcode[5:1];

  // Next-state selection and retire detection
  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (r_ctrl[c_PCWC] || r_ctrl[c_PCW]) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (r_ctrl[c_MEMR] || r_ctrl[c_MEMW]) begin
          w_next = S_MEM;
        end else if (r_ctrl[c_REGW]) begin
          w_next = S_WB;
        end else begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_MEM: begin
        if (!mem_ready) begin
          w_next = S_MEM;
        end else if (r_ctrl[c_MEMR]) begin
          w_next = S_WB;
        end else begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      // Unused encodings recover to FETCH without retiring
      default: w_next = S_FETCH;
    endcase
  end

  // State, latched control word and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ctrl    <= 14'd0;
      r_bne     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_ctrl <= ctrl_word;
        r_bne  <= opcode[0];
      end
      if (w_retire) begin
        r_retired <= r_retired + c_ONE;
      end
    end
  end

  // Strobe decode; reset forces every strobe low combinationally
  always_comb begin
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    ir_we     = 1'b0;
    iord      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_byte  = 1'b0;
    alu_op    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    reg_dst   = 2'b00;
    mem2reg   = 1'b0;
    reg_we    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_EXEC: begin
        alu_op    = r_ctrl[c_ALUOP];
        alu_src_a = r_ctrl[c_SA];
        alu_src_b = r_ctrl[c_SB_HI:c_SB_LO];
        pc_src    = r_ctrl[c_PCS];
        if (r_ctrl[c_PCWC]) begin
          pc_we = zero ^ r_bne;
        end else if (r_ctrl[c_PCW]) begin
          pc_we = 1'b1;
          // JAL links in the same cycle as the jump
          if (r_ctrl[c_REGW]) begin
            reg_we  = 1'b1;
            reg_dst = r_ctrl[c_RD_HI:c_RD_LO];
          end
        end
      end
      S_MEM: begin
        iord     = 1'b1;
        mem_byte = r_ctrl[c_MEMBYTE];
        mem_rd   = r_ctrl[c_MEMR];
        // A read wins if both are set, so the port never sees both
        mem_wr   = r_ctrl[c_MEMW] & ~r_ctrl[c_MEMR];
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = r_ctrl[c_RD_HI:c_RD_LO];
        mem2reg = r_ctrl[c_MEM2REG];
      end
      default: begin
      end
    endcase
    if (rst) begin
      pc_we     = 1'b0;
      pc_src    = 1'b0;
      ir_we     = 1'b0;
      iord      = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_byte  = 1'b0;
      alu_op    = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      reg_dst   = 2'b00;
      mem2reg   = 1'b0;
      reg_we    = 1'b0;
    end
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl_seq
// Description : Directed table-driven bench for mc_ctrl_seq, plus hand-written
//               sequences for reset and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_seq;

  logic        clk;
  logic        rst;
  logic [13:0] ctrl_word;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, mem_byte;
  logic        alu_op, alu_src_a, mem2reg, reg_we;
  logic [1:0]  alu_src_b, reg_dst;
  logic [2:0]  state;
  logic [31:0] retired;

  logic        n_pc_we, n_pc_src, n_ir_we, n_iord, n_mem_rd, n_mem_wr, n_mem_byte;
  logic        n_alu_op, n_alu_src_a, n_mem2reg, n_reg_we;
  logic [1:0]  n_alu_src_b, n_reg_dst;
  logic [2:0]  n_state;
  logic [1:0]  n_retired;

  mc_ctrl_seq #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ctrl_word(ctrl_word), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .iord(iord),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byte(mem_byte),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .reg_we(reg_we),
    .state(state), .retired(retired)
  );

  // Narrow counter instance: exercises wrap from all-ones to zero
  mc_ctrl_seq #(.CNT_W(2)) dut_narrow (
    .clk(clk), .rst(rst), .ctrl_word(ctrl_word), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready),
    .pc_we(n_pc_we), .pc_src(n_pc_src), .ir_we(n_ir_we), .iord(n_iord),
    .mem_rd(n_mem_rd), .mem_wr(n_mem_wr), .mem_byte(n_mem_byte),
    .alu_op(n_alu_op), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
    .reg_dst(n_reg_dst), .mem2reg(n_mem2reg), .reg_we(n_reg_we),
    .state(n_state), .retired(n_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] cw;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [2:0]  st;
    logic [14:0] strb;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  function automatic logic [14:0] o(input logic pcw, pcs, irw, io, mr, mw, mb, ao, sa,
                                    input logic [1:0] sb, rd, input logic m2r, rw);
    return {pcw, pcs, irw, io, mr, mw, mb, ao, sa, sb, rd, m2r, rw};
  endfunction

  function automatic logic [14:0] strobes();
    return {pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, mem_byte,
            alu_op, alu_src_a, alu_src_b, reg_dst, mem2reg, reg_we};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [13:0] cw, input logic [5:0] op, input logic z,
                     input logic rdy, input logic [2:0] st, input logic [14:0] strb,
                     input logic [31:0] ret);
    vec_t v;
    v.cw = cw; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.strb = strb; v.ret = ret;
    vecs.push_back(v);
  endtask

  localparam logic [13:0] c_X     = 14'h3FFF;
  localparam logic [13:0] c_RTYPE = 14'b01100010100000;
  localparam logic [13:0] c_LW    = 14'b00110001110000;
  localparam logic [13:0] c_SB    = 14'b10110000001000;
  localparam logic [13:0] c_SW    = 14'b00110000001000;
  localparam logic [13:0] c_BR    = 14'b00011000000010;
  localparam logic [13:0] c_JAL   = 14'b00011100100101;
  localparam logic [13:0] c_J     = 14'b00011000000001;

  logic [14:0] f_rdy, f_wait, dec, zeros;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    f_rdy  = o(1,0,1,0,1,0,0,0,0,2'b01,2'b00,0,0);
    f_wait = o(0,0,0,0,1,0,0,0,0,2'b01,2'b00,0,0);
    dec    = o(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0);
    zeros  = 15'd0;

    // R-type: F, D, E, WB
    add(c_X,     6'h3F, 1, 1, 3'd0, f_rdy, 0);
    add(c_RTYPE, 6'h00, 1, 0, 3'd1, dec, 0);
    add(c_X,     6'h3F, 1, 1, 3'd2, o(0,0,0,0,0,0,0,1,1,2'b00,2'b00,0,0), 0);
    add(c_X,     6'h3F, 1, 1, 3'd4, o(0,0,0,0,0,0,0,0,0,2'b00,2'b01,0,1), 0);
    // LW with two MEM wait cycles
    add(c_X,  6'h3F, 0, 1, 3'd0, f_rdy, 1);
    add(c_LW, 6'h23, 0, 0, 3'd1, dec, 1);
    add(c_X,  6'h3F, 0, 1, 3'd2, o(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0), 1);
    add(c_X,  6'h3F, 0, 0, 3'd3, o(0,0,0,1,1,0,0,0,0,2'b00,2'b00,0,0), 1);
    add(c_X,  6'h3F, 0, 0, 3'd3, o(0,0,0,1,1,0,0,0,0,2'b00,2'b00,0,0), 1);
    add(c_X,  6'h3F, 0, 1, 3'd3, o(0,0,0,1,1,0,0,0,0,2'b00,2'b00,0,0), 1);
    add(c_X,  6'h3F, 0, 1, 3'd4, o(0,0,0,0,0,0,0,0,0,2'b00,2'b00,1,1), 1);
    // SB: byte store, no WB
    add(c_X,  6'h3F, 0, 1, 3'd0, f_rdy, 2);
    add(c_SB, 6'h28, 0, 0, 3'd1, dec, 2);
    add(c_X,  6'h3F, 0, 1, 3'd2, o(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0), 2);
    add(c_X,  6'h3F, 0, 1, 3'd3, o(0,0,0,1,0,1,1,0,0,2'b00,2'b00,0,0), 2);
    // BEQ taken / not taken
    add(c_X,  6'h3F, 0, 1, 3'd0, f_rdy, 3);
    add(c_BR, 6'h04, 0, 0, 3'd1, dec, 3);
    add(c_X,  6'h3F, 1, 1, 3'd2, o(1,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0), 3);
    add(c_X,  6'h3F, 0, 1, 3'd0, f_rdy, 4);
    add(c_BR, 6'h04, 1, 0, 3'd1, dec, 4);
    add(c_X,  6'h3F, 0, 1, 3'd2, o(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0), 4);
    // BNE: zero=1 not taken, zero=0 taken
    add(c_X,  6'h3E, 0, 1, 3'd0, f_rdy, 5);
    add(c_BR, 6'h05, 0, 0, 3'd1, dec, 5);
    add(c_X,  6'h3E, 1, 1, 3'd2, o(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0), 5);
    add(c_X,  6'h3E, 1, 1, 3'd0, f_rdy, 6);
    add(c_BR, 6'h05, 1, 0, 3'd1, dec, 6);
    add(c_X,  6'h3E, 0, 1, 3'd2, o(1,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0), 6);
    // JAL then J
    add(c_X,   6'h3F, 0, 1, 3'd0, f_rdy, 7);
    add(c_JAL, 6'h03, 0, 0, 3'd1, dec, 7);
    add(c_X,   6'h3F, 0, 1, 3'd2, o(1,1,0,0,0,0,0,0,0,2'b11,2'b10,0,1), 7);
    add(c_X,   6'h3F, 0, 1, 3'd0, f_rdy, 8);
    add(c_J,   6'h02, 0, 0, 3'd1, dec, 8);
    add(c_X,   6'h3F, 0, 1, 3'd2, o(1,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0), 8);
    // FETCH stall for 4 cycles, then a no-op instruction
    for (int i = 0; i < 4; i++) add(c_X, 6'h3F, 1, 0, 3'd0, f_wait, 9);
    add(c_X,   6'h3F, 1, 1, 3'd0, f_rdy, 9);
    add(14'd0, 6'h00, 1, 0, 3'd1, dec, 9);
    add(c_X,   6'h3F, 1, 1, 3'd2, zeros, 9);
    add(c_X,   6'h3F, 1, 0, 3'd0, f_wait, 10);

    // Reset state: strobes held low even with mem_ready high in FETCH
    rst = 1'b1; ctrl_word = c_X; opcode = 6'h3F; zero = 1'b1; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_strobes", {17'd0, strobes()}, 32'd0);
    chk("reset_state",   {29'd0, state}, 32'd0);
    chk("reset_retired", retired, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      ctrl_word = vecs[i].cw;
      opcode    = vecs[i].op;
      zero      = vecs[i].z;
      mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_strobes", i), {17'd0, strobes()}, {17'd0, vecs[i].strb});
      chk($sformatf("v%0d_state", i),   {29'd0, state}, {29'd0, vecs[i].st});
      chk($sformatf("v%0d_retired", i), retired, vecs[i].ret);
      chk($sformatf("v%0d_ret_wrap", i), {30'd0, n_retired}, {30'd0, vecs[i].ret[1:0]});
      if (mem_rd && mem_wr) chk("rd_wr_exclusive", 32'd1, 32'd0);
      @(negedge clk);
    end

    // SW aborted by reset while its MEM request is pending
    ctrl_word = c_X; opcode = 6'h3F; mem_ready = 1'b1;
    @(negedge clk);
    ctrl_word = c_SW; opcode = 6'h2B; mem_ready = 1'b0;
    @(negedge clk);
    ctrl_word = c_X;
    @(negedge clk);
    #1;
    chk("sw_mem_state", {29'd0, state}, 32'd3);
    chk("sw_mem_wr",    {31'd0, mem_wr}, 32'd1);
    chk("sw_iord",      {31'd0, iord}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_mem_wr",  {31'd0, mem_wr}, 32'd0);
    chk("abort_strobes", {17'd0, strobes()}, 32'd0);
    chk("abort_state",   {29'd0, state}, 32'd0);
    chk("abort_retired", retired, 32'd0);
    chk("abort_ret_n",   {30'd0, n_retired}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    chk("post_reset_fetch", {17'd0, strobes()}, {17'd0, f_rdy});

    // Narrow counter: three no-op instructions reach all-ones, the fourth wraps
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ctrl_word = 14'd0; mem_ready = 1'b0;
      @(negedge clk);
      ctrl_word = c_X;
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk($sformatf("wrap_%0d", k), {30'd0, n_retired}, (k == 4) ? 32'd0 : k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl_seq.md
Name: mc_ctrl_seq

Overview:
- Multi-cycle control sequencer for the CPU.
- Consumes the 14-bit static control word from the opcode decoder, plus the opcode, the ALU zero flag and the memory ready handshake.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and emits per-cycle datapath strobes.
- Sits between the opcode decoder and the datapath/memory port; counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ctrl_word  in  14  decoder bundle: 13 Membyte, 12 ALUOP, 11 SA, 10-9 SB, 8-7 RegDst, 6 Mem2Reg, 5 RegW, 4 MemR, 3 MemW, 2 PC_S, 1 PCWC, 0 PCW
- opcode  in  6  current IR opcode; bit0 distinguishes bne (6'h5) from beq (6'h4)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- pc_we  out  1  PC write enable
- pc_src  out  1  0 = ALU result, 1 = jump target
- ir_we  out  1  IR write enable
- iord  out  1  memory address select, 0 = PC, 1 = ALU out
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem_byte  out  1  byte access
- alu_op  out  1  ALUOP from latched word
- alu_src_a  out  1  SA
- alu_src_b  out  2  SB
- reg_dst  out  2  RegDst
- mem2reg  out  1  writeback source select
- reg_we  out  1  register file write enable
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
- retired  out  CNT_W  retired-instruction count, wraps

Behaviour:
Reset
- rst high: state=FETCH, ctrl_q=0, bne_q=0, retired=0.
- While rst is high every strobe output is forced 0.
- After release, FETCH strobes assert on the first cycle.

Latching
- ctrl_q and bne_q = opcode[0] are latched on the DECODE clock edge only.
- EXEC/MEM/WB decodes use ctrl_q and bne_q exclusively; input changes after DECODE are ignored.
- Outputs are combinational decodes of state, ctrl_q and the live zero/mem_ready inputs. All register updates occur on rising clk edges.

FETCH
- Outputs: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, pc_src=0.
- On the mem_ready cycle: ir_we=1, pc_we=1, then go to DECODE.
- Without mem_ready: hold FETCH, with ir_we=0 and pc_we=0.

DECODE
- alu_src_a=0, alu_src_b=11 (branch target precompute).
- Always 1 cycle, then EXEC.

EXEC
- alu_op=ctrl_q[12], alu_src_a=ctrl_q[11], alu_src_b=ctrl_q[10:9], pc_src=ctrl_q[2].
- PCWC=1: pc_we = zero XOR bne_q; go to FETCH, retire.
- PCW=1: pc_we=1. If RegW (JAL): reg_we=1 and reg_dst=ctrl_q[8:7] in the same cycle. Go to FETCH, retire.
- Otherwise, MemR or MemW set: go to MEM.
- Otherwise, RegW: go to WB.
- Otherwise: go to FETCH, retire.

MEM
- iord=1, mem_byte=ctrl_q[13]; mem_rd=MemR, or mem_wr=MemW.
- Request is held every cycle until mem_ready.
- On mem_ready: if MemR go to WB, else (store) go to FETCH and retire.
- If both MemR and MemW are set (illegal), MemR takes priority and mem_wr=0.

WB
- reg_we=1, reg_dst=ctrl_q[8:7], mem2reg=ctrl_q[6].
- Then FETCH, retire.

Invariants
- pc_we and ir_we are never asserted outside FETCH/EXEC.
- mem_rd and mem_wr are never both 1.

Retire counter and illegal state
- retired increments by 1 on each edge where the state goes to FETCH from EXEC, MEM or WB.
- Wraps to 0 from all-ones.
- Unused state encodes 5-7 go to FETCH next cycle with all strobes 0.

Reset mid-operation
- Asynchronous abort from any state, including a pending MEM request.
- mem_rd/mem_wr drop combinationally with rst.
- No retire is counted.

Test Plan:
- R-type, ctrl_word=14'b01100010100000, mem_ready=1 -> FETCH,DECODE,EXEC,WB in 4 cycles; WB reg_we=1, reg_dst=01, mem2reg=0; retired 0->1.
- LW, 14'b00110001110000, mem_ready low 2 cycles in MEM -> mem_rd=1, iord=1 for 3 cycles; then WB with mem2reg=1, reg_we=1. SB, 14'b10110000001000 -> mem_wr=1, mem_byte=1 in MEM, then FETCH; no WB.
- BEQ, opcode=6'h4, 14'b00011000000010: zero=1 -> pc_we=1, pc_src=0 in EXEC; zero=0 -> pc_we=0. BNE, opcode=6'h5, inverts both cases. Each branch ends in FETCH after 3 states.
- JAL, 14'b00011100100101 -> EXEC pc_we=1, pc_src=1, reg_we=1, reg_dst=10 in one cycle; next state FETCH; J (14'b00011000000001) gives reg_we=0.
- FETCH stall: mem_ready low 4 cycles -> ir_we=0, pc_we=0 throughout; state stays 0; ir_we=pc_we=1 exactly on the ready cycle.
- rst pulsed mid-MEM of SW -> mem_wr falls immediately; state=0, retired=0. Force retired=all-ones, retire once -> 0.
